// File: rtl/erreur_quadratique.sv
// Sum and mean of squared errors between prediction and reference over N_ECH samples.
// The datapath has two stages: |difference| first, then squaring and accumulation.
module erreur_quadratique #(
    parameter int unsigned N_ECH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] y_pred,
    input  logic [15:0] y_reel,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [39:0] sse,
    output logic [31:0] mse,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int unsigned SHIFT = $clog2(N_ECH);
    localparam int unsigned CW    = SHIFT + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     e_q, e_d;
    logic            s1_valid_q, s1_valid_d;
    logic [39:0]     acc_q, acc_d;
    logic [39:0]     sse_q, sse_d;
    logic [31:0]     mse_q, mse_d;
    logic            accept;
    logic [31:0]     sq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (accept && (cnt_q == CW'(N_ECH - 1))) state_d = FLUSH;
            FLUSH:   if (!s1_valid_q) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == DONE);
    end

    assign accept = in_valid && (state_q == ACCUM);
    assign sq     = 32'(e_q) * 32'(e_q);

    always_comb begin
        cnt_d      = cnt_q;
        e_d        = e_q;
        s1_valid_d = accept;
        acc_d      = acc_q;
        sse_d      = sse_q;
        mse_d      = mse_q;
        // Magnitude of the difference without wrap-around.
        if (accept) begin
            e_d   = (y_pred >= y_reel) ? (y_pred - y_reel) : (y_reel - y_pred);
            cnt_d = cnt_q + 1'b1;
        end
        if (s1_valid_q) begin
            acc_d = acc_q + {8'b0, sq};
        end
        if ((state_q == IDLE) && start) begin
            cnt_d = '0;
            acc_d = '0;
        end
        // Results are published only once the whole measurement is complete.
        if ((state_q == FLUSH) && !s1_valid_q) begin
            sse_d = acc_q;
            mse_d = acc_q[SHIFT +: 32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            e_q        <= '0;
            s1_valid_q <= 1'b0;
            acc_q      <= '0;
            sse_q      <= '0;
            mse_q      <= '0;
        end else begin
            cnt_q      <= cnt_d;
            e_q        <= e_d;
            s1_valid_q <= s1_valid_d;
            acc_q      <= acc_d;
            sse_q      <= sse_d;
            mse_q      <= mse_d;
        end
    end

    assign sse = sse_q;
    assign mse = mse_q;

endmodule

// File: doc/erreur_quadratique.md
ERREUR_QUADRATIQUE -- requirements
Module: erreur_quadratique

Interface
REQ-001 SHALL have parameter N_ECH, default 8, number of samples per measurement; power of two, 2..256.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a new measurement.
REQ-005 SHALL have port y_pred  input  16  unsigned prediction from regression_lineaire output y.
REQ-006 SHALL have port y_reel  input  16  unsigned reference value for the same sample.
REQ-007 SHALL have port in_valid  input  1  y_pred/y_reel pair valid.
REQ-008 SHALL have port in_ready  output  1  block accepts a pair this cycle.
REQ-009 SHALL have port sse  output  40  sum of squared errors of completed measurement.
REQ-010 SHALL have port mse  output  32  mean squared error, sse / N_ECH.
REQ-011 SHALL have port out_valid  output  1  sse/mse valid.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.

Function
REQ-013 SHALL implement states IDLE, ACCUM, FLUSH, DONE.
REQ-014 IDLE: start=1 SHALL clear accumulator and sample counter and enter ACCUM next cycle; start ignored in all other states.
REQ-015 in_ready SHALL be 1 only in ACCUM; a pair is accepted on a cycle where in_valid=1 and in_ready=1.
REQ-016 Stage 1 on accept SHALL register e = |y_pred - y_reel| (16 bit, computed in 17-bit signed, no wrap) and a stage-1 valid flag.
REQ-017 Stage 2, cycle after a valid stage 1, SHALL add e*e (32-bit, exact) into a 40-bit accumulator.
REQ-018 Sample counter SHALL increment per accepted pair; on the N_ECH-th accept the state SHALL go to FLUSH and in_ready SHALL drop the next cycle.
REQ-019 FLUSH SHALL last until stage 2 has absorbed the last sample, then enter DONE; out_valid SHALL rise exactly 2 cycles after the clock edge that accepted the last pair.
REQ-020 In DONE, sse SHALL equal the accumulator and mse SHALL equal sse >> log2(N_ECH), truncated to 32 bits (no overflow possible for N_ECH≤256).
REQ-021 out_valid, sse, mse SHALL hold stable in DONE until out_valid=1 and out_ready=1; then state returns to IDLE next cycle with out_valid=0.
REQ-022 start coincident with the out_ready handshake SHALL be ignored; a new measurement requires start in IDLE.
REQ-023 sse and mse SHALL keep last completed values after leaving DONE until the next measurement completes; they SHALL NOT show partial sums.
REQ-024 in_valid=0 cycles in ACCUM SHALL stall without losing count or accumulator contents.
REQ-025 y_pred=y_reel SHALL contribute 0; e=65535 SHALL contribute 4294836225 exactly.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, in_ready=0, out_valid=0, sse=0, mse=0, counter=0, accumulator=0, stage-1 valid=0.
REQ-027 Reset asserted mid-ACCUM or mid-DONE SHALL abort the measurement; after release no output changes until a new start.
REQ-028 Deassertion SHALL take effect on the next rising clk edge; first start is honoured on the first edge after release.

Verification
REQ-029 N_ECH=8, start, 8 pairs back-to-back y_pred=100, y_reel=90 -> sse=800, mse=100, out_valid 2 cycles after 8th accept.
REQ-030 N_ECH=8, pairs alternating (0,65535) and (65535,0) -> sse=34358689800, mse=4294836225, no overflow.
REQ-031 Same as REQ-029 with in_valid low every other cycle -> identical results, in_ready only in ACCUM, exactly 8 accepts counted.
REQ-032 Result held with out_ready=0 for 10 cycles, start pulsed during hold -> sse/mse/out_valid stable, start ignored; out_ready=1 -> IDLE next cycle.
REQ-033 rst_n pulsed low after 4 of 8 samples -> all outputs 0 immediately; new start plus 8 pairs (y_pred=5,y_reel=7) -> sse=32, mse=4.
REQ-034 Pairs with in_valid=1 in IDLE or DONE -> not accepted, in_ready=0, accumulator unchanged.
